// File: rtl/rat_int_ctrl_pkg.sv
// rtl/rat_int_ctrl_pkg.sv - shared types and defaults for the RAT interrupt controller
//
// Purpose: FSM state enum and default vector constants.
// Ports:   none (package rat_pkg).
package rat_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } int_state_t;

  localparam int         RAT_VEC_W        = 10;
  localparam logic [9:0] RAT_INT_VEC_BASE = 10'h3F0;

endpackage

// File: rtl/rat_int_ctrl_if.sv
// rtl/rat_int_ctrl_if.sv - control-unit side bus of the RAT interrupt controller
//
// Purpose: groups request lines, mask write, handshake and status signals.
// Ports:   none; modport slave is the controller, modport master is the
//          control unit / stimulus side.
//   IRQ[NUM_SRC]        source request lines
//   INT_EN              global enable (I flag)
//   MASK_WE, MASK_DIN   mask write strobe / value
//   INT_ACK, RETI       accept current request / ISR return
//   INT_REQ, INT_ID, INT_VEC   request, winning source, its vector
//   PENDING, IN_SERVICE status registers
interface rat_int_ctrl_if
  import rat_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int VEC_W   = RAT_VEC_W
) ();

  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] IRQ;
  logic               INT_EN;
  logic               MASK_WE;
  logic [NUM_SRC-1:0] MASK_DIN;
  logic               INT_ACK;
  logic               RETI;
  logic               INT_REQ;
  logic [ID_W-1:0]    INT_ID;
  logic [VEC_W-1:0]   INT_VEC;
  logic [NUM_SRC-1:0] PENDING;
  logic [NUM_SRC-1:0] IN_SERVICE;

  modport master (
    output IRQ, INT_EN, MASK_WE, MASK_DIN, INT_ACK, RETI,
    input  INT_REQ, INT_ID, INT_VEC, PENDING, IN_SERVICE
  );

  modport slave (
    input  IRQ, INT_EN, MASK_WE, MASK_DIN, INT_ACK, RETI,
    output INT_REQ, INT_ID, INT_VEC, PENDING, IN_SERVICE
  );

endinterface

// File: rtl/rat_int_ctrl_prio_enc.sv
// rtl/rat_int_ctrl_prio_enc.sv - lowest-index-first priority encoder
//
// Purpose: finds the lowest set bit of a request vector.
// Ports:
//   req_i[N]    request vector
//   valid_o     any bit of req_i set
//   id_o        index of the lowest set bit (0 when none set)
module rat_prio_enc #(
  parameter  int N    = 8,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  output logic            valid_o,
  output logic [ID_W-1:0] id_o
);

  // Scan downward so the last hit, i.e. the lowest index, is kept.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rat_int_ctrl.sv
// rtl/rat_int_ctrl.sv - multi-source fixed-priority interrupt controller for the RAT MCU
//
// Purpose: edge-detects NUM_SRC request lines into a pending register, masks
//          them, picks the lowest-index eligible source and presents it to the
//          control unit through an INT_REQ/INT_ACK handshake; tracks in-service
//          sources until RETI.
// Ports:
//   CLK     rising-edge clock
//   RESET   asynchronous active-low reset
//   bus     rat_int_ctrl_if.slave (IRQ, INT_EN, MASK_WE/MASK_DIN, INT_ACK,
//           RETI in; INT_REQ, INT_ID, INT_VEC, PENDING, IN_SERVICE out)
// Config:  RAT_INT_NEST_EN defined   -> a source lower than the lowest
//                                       in-service source may nest.
//          RAT_INT_NEST_EN undefined -> nothing is eligible while any source
//                                       is in service.
// The interface instance must use the same NUM_SRC/VEC_W as this module.
module rat_int_ctrl
  import rat_pkg::*;
#(
  parameter int               NUM_SRC  = 8,
  parameter int               VEC_W    = RAT_VEC_W,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(RAT_INT_VEC_BASE)
) (
  input  logic           CLK,
  input  logic           RESET,
  rat_int_ctrl_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q,    pending_d;
  logic [NUM_SRC-1:0] mask_q,       mask_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;

  int_state_t         state_q;
  logic               int_req_q;
  logic [ID_W-1:0]    int_id_q;
  logic [VEC_W-1:0]   int_vec_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] svc_ok;
  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               is_valid;
  logic [ID_W-1:0]    is_id;
  logic               ack_take;
  logic               withdraw;

  assign rise = bus.IRQ & ~irq_q;

  // Lowest in-service source: gates nesting and is the bit RETI retires.
  rat_prio_enc #(.N(NUM_SRC)) u_svc_enc (
    .req_i   (in_service_q),
    .valid_o (is_valid),
    .id_o    (is_id)
  );

`ifdef RAT_INT_NEST_EN
  always_comb begin
    svc_ok = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      svc_ok[i] = !is_valid || (ID_W'(i) < is_id);
    end
  end
`else
  assign svc_ok = {NUM_SRC{~is_valid}};
`endif

  assign eligible = pending_q & mask_q & {NUM_SRC{bus.INT_EN}} & svc_ok;

  rat_prio_enc #(.N(NUM_SRC)) u_win_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  // The ack is checked before the withdraw conditions, so an ack that
  // coincides with a mask write or INT_EN drop is still taken.
  assign ack_take = (state_q == REQ) && bus.INT_ACK;
  assign withdraw = (state_q == REQ) && !bus.INT_ACK &&
                    (!bus.INT_EN || !mask_q[int_id_q]);

  always_comb begin
    pending_d = pending_q;
    if (ack_take) begin
      pending_d[int_id_q] = 1'b0;
    end
    // Set after the ack clear: an edge coinciding with its own ack is queued.
    pending_d = pending_d | rise;

    in_service_d = in_service_q;
    if (bus.RETI && is_valid) begin
      in_service_d[is_id] = 1'b0;
    end
    if (ack_take) begin
      in_service_d[int_id_q] = 1'b1;
    end

    mask_d = bus.MASK_WE ? bus.MASK_DIN : mask_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
    end else begin
      irq_q        <= bus.IRQ;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
    end
  end

  // Request FSM. The winner is frozen on entry to REQ; no re-arbitration.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
      int_vec_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q   <= REQ;
            int_req_q <= 1'b1;
            int_id_q  <= win_id;
            int_vec_q <= VEC_BASE + VEC_W'(win_id);
          end
        end
        REQ: begin
          if (ack_take || withdraw) begin
            state_q   <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INT_REQ    = int_req_q;
  assign bus.INT_ID     = int_id_q;
  assign bus.INT_VEC    = int_vec_q;
  assign bus.PENDING    = pending_q;
  assign bus.IN_SERVICE = in_service_q;

endmodule

// File: tb/tb_rat_int_ctrl.sv
// tb/tb_rat_int_ctrl.sv - directed self-checking bench for rat_int_ctrl
module tb_rat_int_ctrl;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  rat_int_ctrl_if #(.NUM_SRC(8), .VEC_W(10)) bus ();

  rat_int_ctrl #(.NUM_SRC(8), .VEC_W(10), .VEC_BASE(10'h3F0)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [2:0] id, input logic [9:0] vec);
    chk({tag, "_req"}, 32'(bus.INT_REQ), 32'(req));
    if (req) begin
      chk({tag, "_id"},  32'(bus.INT_ID),  32'(id));
      chk({tag, "_vec"}, 32'(bus.INT_VEC), 32'(vec));
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    RESET       = 1'b0;
    bus.IRQ     = '0;
    bus.INT_EN  = 1'b1;
    bus.MASK_WE = 1'b0;
    bus.MASK_DIN = '0;
    bus.INT_ACK = 1'b0;
    bus.RETI    = 1'b0;

    // Reset state
    tick();
    chk("rst_req",  32'(bus.INT_REQ),    32'h0);
    chk("rst_id",   32'(bus.INT_ID),     32'h0);
    chk("rst_vec",  32'(bus.INT_VEC),    32'h0);
    chk("rst_pend", 32'(bus.PENDING),    32'h0);
    chk("rst_isv",  32'(bus.IN_SERVICE), 32'h0);
    tick();
    RESET = 1'b1;
    tick();

    // Single source 3: 1 edge to pending, 2 edges to request
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 8'hFF;
    tick();
    bus.MASK_WE = 1'b0;
    bus.IRQ = 8'h08;
    tick();
    chk("s3_pend", 32'(bus.PENDING), 32'h08);
    chk("s3_req_early", 32'(bus.INT_REQ), 32'h0);
    bus.IRQ = 8'h00;
    tick();
    chk_req("s3", 1'b1, 3'd3, 10'h3F3);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("s3_ack_req",  32'(bus.INT_REQ),    32'h0);
    chk("s3_ack_isv",  32'(bus.IN_SERVICE), 32'h08);
    chk("s3_ack_pend", 32'(bus.PENDING),    32'h00);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    chk("s3_reti_isv", 32'(bus.IN_SERVICE), 32'h00);

    // Sources 5 and 2 together: 2 first, 5 after RETI
    bus.IRQ = 8'h24;
    tick();
    chk("p52_pend", 32'(bus.PENDING), 32'h24);
    bus.IRQ = 8'h00;
    tick();
    chk_req("p52_first", 1'b1, 3'd2, 10'h3F2);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("p52_isv",  32'(bus.IN_SERVICE), 32'h04);
    chk("p52_pend2", 32'(bus.PENDING),   32'h20);
    tick();
    chk("p52_blocked", 32'(bus.INT_REQ), 32'h0);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    chk("p52_reti_isv", 32'(bus.IN_SERVICE), 32'h00);
    tick();
    chk_req("p52_second", 1'b1, 3'd5, 10'h3F5);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("p52_isv5", 32'(bus.IN_SERVICE), 32'h20);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;

    // Source 6 in service, then source 1 raised
    bus.IRQ = 8'h40;
    tick();
    bus.IRQ = 8'h00;
    tick();
    chk_req("s6", 1'b1, 3'd6, 10'h3F6);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("s6_isv", 32'(bus.IN_SERVICE), 32'h40);
    bus.IRQ = 8'h02;
    tick();
    chk("s1_pend", 32'(bus.PENDING), 32'h02);
    bus.IRQ = 8'h00;
    tick();
`ifdef RAT_INT_NEST_EN
    chk_req("nest_s1", 1'b1, 3'd1, 10'h3F1);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("nest_isv", 32'(bus.IN_SERVICE), 32'h42);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    chk("nest_reti", 32'(bus.IN_SERVICE), 32'h40);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    chk("nest_reti2", 32'(bus.IN_SERVICE), 32'h00);
`else
    chk("nonest_blk", 32'(bus.INT_REQ), 32'h0);
    tick();
    chk("nonest_blk2", 32'(bus.INT_REQ), 32'h0);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    chk("nonest_reti", 32'(bus.IN_SERVICE), 32'h00);
    tick();
    chk_req("nonest_s1", 1'b1, 3'd1, 10'h3F1);
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("nonest_isv", 32'(bus.IN_SERVICE), 32'h02);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
`endif

    // Masked source 4, then unmask; ack wins over a simultaneous mask write
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 8'h00;
    tick();
    bus.MASK_WE = 1'b0;
    bus.IRQ = 8'h10;
    tick();
    chk("m4_pend", 32'(bus.PENDING), 32'h10);
    bus.IRQ = 8'h00;
    tick();
    chk("m4_noreq", 32'(bus.INT_REQ), 32'h0);
    bus.MASK_WE = 1'b1; bus.MASK_DIN = 8'h10;
    tick();
    bus.MASK_WE = 1'b0;
    chk("m4_noreq2", 32'(bus.INT_REQ), 32'h0);
    tick();
    chk_req("m4", 1'b1, 3'd4, 10'h3F4);
    bus.INT_ACK = 1'b1; bus.MASK_WE = 1'b1; bus.MASK_DIN = 8'h00;
    tick();
    bus.INT_ACK = 1'b0; bus.MASK_WE = 1'b0;
    chk("m4_ackwin_req",  32'(bus.INT_REQ),    32'h0);
    chk("m4_ackwin_isv",  32'(bus.IN_SERVICE), 32'h10);
    chk("m4_ackwin_pend", 32'(bus.PENDING),    32'h00);
    bus.RETI = 1'b1; bus.MASK_WE = 1'b1; bus.MASK_DIN = 8'hFF;
    tick();
    bus.RETI = 1'b0; bus.MASK_WE = 1'b0;

    // INT_EN drop withdraws, re-raise requests again
    bus.IRQ = 8'h01;
    tick();
    bus.IRQ = 8'h00;
    tick();
    chk_req("en_s0", 1'b1, 3'd0, 10'h3F0);
    bus.INT_EN = 1'b0;
    tick();
    chk("en_drop_req",  32'(bus.INT_REQ), 32'h0);
    chk("en_drop_pend", 32'(bus.PENDING), 32'h01);
    bus.INT_EN = 1'b1;
    tick();
    chk_req("en_again", 1'b1, 3'd0, 10'h3F0);

    // Edge coinciding with its own ack is queued
    bus.IRQ = 8'h01; bus.INT_ACK = 1'b1;
    tick();
    bus.IRQ = 8'h00; bus.INT_ACK = 1'b0;
    chk("q_pend", 32'(bus.PENDING),    32'h01);
    chk("q_isv",  32'(bus.IN_SERVICE), 32'h01);
    chk("q_req",  32'(bus.INT_REQ),    32'h0);
    tick();
    chk("q_blk", 32'(bus.INT_REQ), 32'h0);
    // Edge on an already-pending source is absorbed
    bus.IRQ = 8'h01; bus.RETI = 1'b1;
    tick();
    bus.IRQ = 8'h00; bus.RETI = 1'b0;
    chk("abs_isv",  32'(bus.IN_SERVICE), 32'h00);
    chk("abs_pend", 32'(bus.PENDING),    32'h01);
    tick();
    chk_req("abs_req", 1'b1, 3'd0, 10'h3F0);
    // RETI with nothing in service is ignored; the ack still sets its bit
    bus.INT_ACK = 1'b1; bus.RETI = 1'b1;
    tick();
    bus.INT_ACK = 1'b0; bus.RETI = 1'b0;
    chk("ackreti_isv",  32'(bus.IN_SERVICE), 32'h01);
    chk("ackreti_pend", 32'(bus.PENDING),    32'h00);
    bus.RETI = 1'b1;
    tick();
    bus.RETI = 1'b0;
    // Ack in IDLE is ignored
    bus.INT_ACK = 1'b1;
    tick();
    bus.INT_ACK = 1'b0;
    chk("idle_ack_isv", 32'(bus.IN_SERVICE), 32'h00);
    chk("idle_ack_req", 32'(bus.INT_REQ),    32'h0);

    // Reset mid-request with PENDING=8'h81
    bus.IRQ = 8'h81;
    tick();
    chk("r_pend", 32'(bus.PENDING), 32'h81);
    tick();
    chk_req("r_req", 1'b1, 3'd0, 10'h3F0);
    bus.IRQ = 8'h80;
    RESET = 1'b0;
    #1;
    chk("r_async_req",  32'(bus.INT_REQ),    32'h0);
    chk("r_async_id",   32'(bus.INT_ID),     32'h0);
    chk("r_async_vec",  32'(bus.INT_VEC),    32'h0);
    chk("r_async_pend", 32'(bus.PENDING),    32'h0);
    chk("r_async_isv",  32'(bus.IN_SERVICE), 32'h0);
    tick();
    RESET = 1'b1;
    tick();
    chk("r_rel_pend", 32'(bus.PENDING), 32'h80);
    chk("r_rel_req",  32'(bus.INT_REQ), 32'h0);
    tick();
    chk("r_rel_req2", 32'(bus.INT_REQ), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
